// File: rtl/regfile_ctrl_pkg.sv
// Shared types for the register-file controller: default widths, opcode and FSM state encodings.
package regfile_ctrl_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_IDX   = 3;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_LDI = 3'b101,
    OP_SHL = 3'b110,
    OP_NOP = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

endpackage

// File: rtl/regfile_ctrl_alu.sv
// Combinational ALU for the register-file controller: result, carry/borrow and zero flag.
module regfile_ctrl_alu
  import regfile_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] imm_i,
  output logic [WIDTH-1:0] y_o,
  output logic             carry_o,
  output logic             zero_o
);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, a_i} + {1'b0, b_i};

  always_comb begin
    y_o     = '0;
    carry_o = 1'b0;
    case (op_t'(op_i))
      OP_ADD: begin
        y_o     = sum[WIDTH-1:0];
        carry_o = sum[WIDTH];
      end
      OP_SUB: begin
        y_o     = a_i - b_i;
        carry_o = (a_i < b_i);
      end
      OP_AND: y_o = a_i & b_i;
      OP_OR:  y_o = a_i | b_i;
      OP_XOR: y_o = a_i ^ b_i;
      OP_LDI: y_o = imm_i;
      OP_SHL: begin
        y_o     = {a_i[WIDTH-2:0], 1'b0};
        carry_o = a_i[WIDTH-1];
      end
      default: ;
    endcase
    zero_o = (y_o == '0);
  end

endmodule

// File: rtl/regfile_ctrl.sv
// Register-file initiator: accepts one command, reads operands, runs the ALU and writes the result back.
module regfile_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDX   = DEF_IDX
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [IDX-1:0]   cmd_dst,
  input  logic [IDX-1:0]   cmd_srca,
  input  logic [IDX-1:0]   cmd_srcb,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [IDX-1:0]   rf_a_index,
  output logic [IDX-1:0]   rf_b_index,
  output logic [IDX-1:0]   rf_c_index,
  output logic             rf_we,
  output logic [WIDTH-1:0] rf_d,
  input  logic [WIDTH-1:0] rf_a_data,
  input  logic [WIDTH-1:0] rf_b_data,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic [1:0]       dbg_state
);

  state_t           state_q, state_d;
  logic             alive_q;
  op_t              op_q;
  logic [IDX-1:0]   dst_q, srca_q, srcb_q;
  logic [WIDTH-1:0] imm_q, a_q, b_q, result_q;
  logic             zero_q, carry_q;
  logic [WIDTH-1:0] alu_y;
  logic             alu_carry, alu_zero;
  logic             accept;

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE and only once the first edge after reset release has passed.
  assign cmd_ready  = (state_q == ST_IDLE) && alive_q;
  assign accept     = cmd_valid && cmd_ready;
  assign result     = result_q;
  assign flag_zero  = zero_q;
  assign flag_carry = carry_q;
  assign dbg_state  = state_q;

  regfile_ctrl_alu #(.WIDTH(WIDTH)) u_alu (
    .op_i    (op_q),
    .a_i     (a_q),
    .b_i     (b_q),
    .imm_i   (imm_q),
    .y_o     (alu_y),
    .carry_o (alu_carry),
    .zero_o  (alu_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      alive_q  <= 1'b0;
      op_q     <= OP_NOP;
      dst_q    <= '0;
      srca_q   <= '0;
      srcb_q   <= '0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
      if (accept) begin
        op_q   <= op_t'(cmd_op);
        dst_q  <= cmd_dst;
        srca_q <= cmd_srca;
        srcb_q <= cmd_srcb;
        imm_q  <= cmd_imm;
      end
      if (state_q == ST_READ) begin
        a_q <= rf_a_data;
        b_q <= rf_b_data;
      end
      // NOP keeps the previously reported result and flags.
      if (state_q == ST_EXEC && op_q != OP_NOP) begin
        result_q <= alu_y;
        zero_q   <= alu_zero;
        carry_q  <= alu_carry;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rf_a_index = '0;
    rf_b_index = '0;
    rf_c_index = '0;
    rf_we      = 1'b0;
    rf_d       = '0;
    done       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_READ;
      end
      ST_READ: begin
        rf_a_index = srca_q;
        rf_b_index = srcb_q;
        state_d    = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        rf_we      = (op_q != OP_NOP);
        rf_c_index = dst_q;
        rf_d       = result_q;
        done       = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl: register-file model, command-level reference model and per-cycle compare.
module tb_regfile_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [2:0]  cmd_dst, cmd_srca, cmd_srcb;
  logic [15:0] cmd_imm;
  logic [2:0]  rf_a_index, rf_b_index, rf_c_index;
  logic        rf_we;
  logic [15:0] rf_d, rf_a_data, rf_b_data;
  logic        done;
  logic [15:0] result;
  logic        flag_zero, flag_carry;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  regfile_ctrl #(.WIDTH(16), .IDX(3)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_dst    (cmd_dst),
    .cmd_srca   (cmd_srca),
    .cmd_srcb   (cmd_srcb),
    .cmd_imm    (cmd_imm),
    .rf_a_index (rf_a_index),
    .rf_b_index (rf_b_index),
    .rf_c_index (rf_c_index),
    .rf_we      (rf_we),
    .rf_d       (rf_d),
    .rf_a_data  (rf_a_data),
    .rf_b_data  (rf_b_data),
    .done       (done),
    .result     (result),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .dbg_state  (dbg_state)
  );

  // ---------------- register file the DUT drives ----------------
  logic [15:0] rf [8];
  always @(posedge clk) if (rf_we) rf[rf_c_index] <= rf_d;
  assign rf_a_data = rf[rf_a_index];
  assign rf_b_data = rf[rf_b_index];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model (command level) ----------------
  function automatic logic [16:0] alu_model(input logic [2:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input logic [15:0] imm);
    logic [15:0] diff;
    diff = a - b;
    case (op)
      3'd0: return {1'b0, a} + {1'b0, b};
      3'd1: return {(a < b), diff};
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, a ^ b};
      3'd5: return {1'b0, imm};
      3'd6: return {a[15], a[14:0], 1'b0};
      default: return 17'd0;
    endcase
  endfunction

  // m_phase counts cycles since acceptance: 0 idle, 1..3 busy, 3 = write/retire cycle
  int          m_phase;
  logic        m_alive;
  logic [2:0]  m_op, m_dst, m_srca, m_srcb;
  logic [16:0] m_y;
  logic [15:0] m_res;
  logic        m_zero, m_carry;
  logic [15:0] m_rf [8];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase <= 0;
      m_alive <= 1'b0;
      m_res   <= 16'h0;
      m_zero  <= 1'b0;
      m_carry <= 1'b0;
    end else begin
      m_alive <= 1'b1;
      case (m_phase)
        0: if (m_alive && cmd_valid) begin
          m_op    <= cmd_op;
          m_dst   <= cmd_dst;
          m_srca  <= cmd_srca;
          m_srcb  <= cmd_srcb;
          m_y     <= alu_model(cmd_op, m_rf[cmd_srca], m_rf[cmd_srcb], cmd_imm);
          m_phase <= 1;
        end
        1: m_phase <= 2;
        2: begin
          m_phase <= 3;
          if (m_op != 3'd7) begin
            m_res   <= m_y[15:0];
            m_carry <= m_y[16];
            m_zero  <= (m_y[15:0] == 16'h0);
          end
        end
        default: begin
          m_phase <= 0;
          if (m_op != 3'd7) m_rf[m_dst] <= m_y[15:0];
        end
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("cmd_ready",  {31'd0, cmd_ready}, {31'd0, (m_phase == 0) && m_alive});
    check("rf_a_index", {29'd0, rf_a_index}, {29'd0, (m_phase == 1) ? m_srca : 3'd0});
    check("rf_b_index", {29'd0, rf_b_index}, {29'd0, (m_phase == 1) ? m_srcb : 3'd0});
    check("rf_we",      {31'd0, rf_we}, {31'd0, (m_phase == 3) && (m_op != 3'd7)});
    check("done",       {31'd0, done}, {31'd0, m_phase == 3});
    check("rf_c_index", {29'd0, rf_c_index}, {29'd0, (m_phase == 3) ? m_dst : 3'd0});
    check("rf_d",       {16'd0, rf_d}, {16'd0, (m_phase == 3) ? m_res : 16'h0});
    check("result",     {16'd0, result}, {16'd0, m_res});
    check("flag_zero",  {31'd0, flag_zero}, {31'd0, m_zero});
    check("flag_carry", {31'd0, flag_carry}, {31'd0, m_carry});
  end

  // ---------------- driver tasks ----------------
  task automatic set_cmd(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] a,
                         input logic [2:0] b, input logic [15:0] imm);
    cmd_op = op; cmd_dst = dst; cmd_srca = a; cmd_srcb = b; cmd_imm = imm;
  endtask

  // Raise valid, wait (bounded) for ready, return #1 after the accepting edge (READ cycle).
  task automatic issue(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] a,
                       input logic [2:0] b, input logic [15:0] imm);
    bit got = 0;
    int i = 0;
    set_cmd(op, dst, a, b, imm);
    cmd_valid = 1'b1;
    while (!got && i < 20) begin
      @(negedge clk);
      if (cmd_ready) got = 1;
      i++;
    end
    check("accept_timeout", {31'd0, got}, 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic run(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] a,
                     input logic [2:0] b, input logic [15:0] imm);
    issue(op, dst, a, b, imm);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic to_write();
    repeat (3) @(negedge clk);
  endtask

  task automatic to_idle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit got;
    int i;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    set_cmd(3'd0, 3'd0, 3'd0, 3'd0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",  {31'd0, cmd_ready}, 32'd0);
    check("rst_result", {16'd0, result}, 32'd0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1 check("ready_after_release", {31'd0, cmd_ready}, 32'd1);

    // LDI r1 = 0x1234
    issue(3'd5, 3'd1, 3'd0, 3'd0, 16'h1234);
    to_write();
    check("ldi_we",    {31'd0, rf_we}, 32'd1);
    check("ldi_cidx",  {29'd0, rf_c_index}, 32'd1);
    check("ldi_d",     {16'd0, rf_d}, 32'h1234);
    check("ldi_done",  {31'd0, done}, 32'd1);
    check("ldi_res",   {16'd0, result}, 32'h1234);
    check("ldi_zero",  {31'd0, flag_zero}, 32'd0);
    check("ldi_carry", {31'd0, flag_carry}, 32'd0);
    to_idle();

    // ADD r4 = r2 + r3 with r2=FFFF, r3=0001
    run(3'd5, 3'd2, 3'd0, 3'd0, 16'hFFFF);
    run(3'd5, 3'd3, 3'd0, 3'd0, 16'h0001);
    issue(3'd0, 3'd4, 3'd2, 3'd3, 16'h0);
    @(negedge clk);
    check("add_aidx", {29'd0, rf_a_index}, 32'd2);
    check("add_bidx", {29'd0, rf_b_index}, 32'd3);
    repeat (2) @(negedge clk);
    check("add_d",     {16'd0, rf_d}, 32'h0000);
    check("add_zero",  {31'd0, flag_zero}, 32'd1);
    check("add_carry", {31'd0, flag_carry}, 32'd1);
    to_idle();

    // SUB r7 = r5 - r6 with 5 - 7
    run(3'd5, 3'd5, 3'd0, 3'd0, 16'h0005);
    run(3'd5, 3'd6, 3'd0, 3'd0, 16'h0007);
    issue(3'd1, 3'd7, 3'd5, 3'd6, 16'h0);
    to_write();
    check("sub_d",     {16'd0, rf_d}, 32'hFFFE);
    check("sub_carry", {31'd0, flag_carry}, 32'd1);
    check("sub_zero",  {31'd0, flag_zero}, 32'd0);
    to_idle();

    // SHL r1 = r0 << 1 with r0=8001
    run(3'd5, 3'd0, 3'd0, 3'd0, 16'h8001);
    issue(3'd6, 3'd1, 3'd0, 3'd3, 16'h0);
    to_write();
    check("shl_d",     {16'd0, rf_d}, 32'h0002);
    check("shl_carry", {31'd0, flag_carry}, 32'd1);
    to_idle();

    // NOP after ADD: done pulses, no write, result/flags kept
    run(3'd0, 3'd4, 3'd2, 3'd3, 16'h0);
    issue(3'd7, 3'd5, 3'd0, 3'd0, 16'hABCD);
    repeat (2) @(negedge clk);
    check("nop_done_early", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("nop_done",  {31'd0, done}, 32'd1);
    check("nop_we",    {31'd0, rf_we}, 32'd0);
    check("nop_res",   {16'd0, result}, 32'h0000);
    check("nop_zero",  {31'd0, flag_zero}, 32'd1);
    check("nop_carry", {31'd0, flag_carry}, 32'd1);
    to_idle();

    // Back-to-back with valid held: AND r1 = r2&r3, then XOR r2 = r5^r6
    set_cmd(3'd2, 3'd1, 3'd2, 3'd3, 16'h0);
    cmd_valid = 1'b1;
    got = 0;
    i = 0;
    while (!got && i < 20) begin
      @(negedge clk);
      if (cmd_ready) got = 1;
      i++;
    end
    check("b2b_accept_timeout", {31'd0, got}, 32'd1);
    @(posedge clk);
    #1 set_cmd(3'd4, 3'd2, 3'd5, 3'd6, 16'h0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("b2b_busy_ready", {31'd0, cmd_ready}, 32'd0);
    end
    check("b2b_done1", {31'd0, done}, 32'd1);
    check("b2b_d1",    {16'd0, rf_d}, 32'h0001);
    @(negedge clk);
    check("b2b_ready_t4", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("b2b_gap", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("b2b_done2", {31'd0, done}, 32'd1);
    check("b2b_d2",    {16'd0, rf_d}, 32'h0002);
    to_idle();

    // Reset during EXEC of OR r3 = r5|r6: abort, then a normal command
    issue(3'd3, 3'd3, 3'd5, 3'd6, 16'h0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, cmd_ready}, 32'd0);
    check("mid_rst_we",    {31'd0, rf_we}, 32'd0);
    check("mid_rst_done",  {31'd0, done}, 32'd0);
    check("mid_rst_res",   {16'd0, result}, 32'd0);
    check("mid_rst_flags", {30'd0, flag_zero, flag_carry}, 32'd0);
    check("mid_rst_d",     {16'd0, rf_d}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1 check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("r3_untouched", {16'd0, rf[3]}, 32'h0001);
    issue(3'd0, 3'd4, 3'd3, 3'd0, 16'h0);
    to_write();
    check("post_rst_we",    {31'd0, rf_we}, 32'd1);
    check("post_rst_d",     {16'd0, rf_d}, 32'h8002);
    check("post_rst_carry", {31'd0, flag_carry}, 32'd0);
    check("post_rst_zero",  {31'd0, flag_zero}, 32'd0);
    to_idle();

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
